ram_sp_sr_rw: RTL and testbench
===============================

Name: ram_sp_sr_rw

Overview:
Single-port static RAM with synchronous read and synchronous write through one shared address bus. A chip select (`cs`) gates every access. Write enable (`we`) selects write (1) or read (0). Used as generic on-chip storage, for example message/LLR buffers in the LDPC decoder datapath. Reads are registered with one cycle of latency.

Parameters:
- DATA_WIDTH, 8, width of each word in bits.
- ADDR_WIDTH, 8, width of the address bus in bits.
- DEPTH, 256, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous reset, active low.
- address  input  ADDR_WIDTH  word address for both read and write.
- data_in  input  DATA_WIDTH  write data.
- cs  input  1  chip select, active high; when 0 the block is idle.
- we  input  1  1 = write, 0 = read; only meaningful while cs=1.
- data_out  output  DATA_WIDTH  registered read data.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low. Asserting rst_n=0 immediately forces data_out to 0, independent of clk. Deassertion takes effect at the next rising edge.
- Reset does not clear the memory array. Contents are undefined after power-up; software and benches must write a location before reading it.
- Write (cs=1, we=1) at a rising edge:
  - mem[address] <= data_in.
  - data_out holds its previous value (no write-through).
- Read (cs=1, we=0) at a rising edge:
  - data_out <= mem[address].
  - Data is valid after that edge, so latency is 1 cycle.
  - Back-to-back reads give one word per cycle.
- Idle (cs=0): no memory update; data_out holds its previous value. we and address are don't-care.
- Write then read of the same address on consecutive cycles returns the newly written data. No same-cycle read/write collision can occur on a single port.
- Out-of-range address (address >= DEPTH, only possible when DEPTH < 2**ADDR_WIDTH):
  - Write is ignored.
  - Read loads 0 into data_out.
- Reset mid-operation:
  - An access in the same edge as active reset is dropped for data_out.
  - Memory writes are also suppressed while rst_n=0.
  - Previously written contents are retained.
- No handshake and no ready/valid; the block accepts one access every cycle.
- Storage is a plain register array (mem[0:DEPTH-1] of DATA_WIDTH bits) so synthesis can infer block RAM. The array is written only in the clocked process, never in the reset branch.

Decomposition:
- No shared package needed; the only constants are the three parameters.
- No sub-module. Optionally, a shared LDPC package may later hold project defaults for DATA_WIDTH/ADDR_WIDTH, which would then be passed in as parameters.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with data_out=8'h5A, then assert -> data_out becomes 8'h00 immediately (asynchronous), before any clk edge.
- Full write/readback: with cs=1, we=1, write address i (0..255) with a pseudo-random 8-bit value, e.g. addr 0 <- 8'h04, addr 255 <- 8'hF9. Then read addresses 0..255 with we=0 -> each data_out, one cycle after its address, equals the stored value; 256 consecutive reads with no bubbles.
- Read latency/hold: write addr 8'h10 <- 8'hA5, then read addr 8'h10 -> data_out=8'hA5 after exactly one edge. Then set cs=0 for 3 cycles while changing address -> data_out stays 8'hA5.
- Write does not disturb output: read addr 3 (=8'h33), then write addr 3 <- 8'hCC -> data_out stays 8'h33 during the write cycle. The next read of addr 3 gives 8'hCC.
- cs gating: with cs=0, we=1, data_in=8'hFF at addr 7 (previously 8'h07) -> a later read of addr 7 returns 8'h07.
- Reset retention, plus out-of-range: pulse rst_n after writes -> memory contents are preserved on readback. Then with DEPTH=200, write to addr 210 is ignored and a read of addr 210 gives 8'h00.

Source files
------------

// File: rtl/ram_sp_sr_rw_pkg.sv
// ram_sp_sr_rw_pkg
// Purpose: project defaults for the single-port RAM geometry. A future
//          shared LDPC package may take over these defaults; the RAM itself
//          only ever sees them as parameter values.
// Contents: DEF_DATA_WIDTH, DEF_ADDR_WIDTH, DEF_DEPTH.
package ram_sp_sr_rw_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DEPTH      = 256;

endpackage : ram_sp_sr_rw_pkg

// File: rtl/ram_sp_sr_rw.sv
// ram_sp_sr_rw
// Purpose: single-port static RAM, synchronous write and registered
//          (1-cycle latency) synchronous read through one address bus.
//          Interface contract: there is no handshake. Every rising edge with
//          cs=1 performs exactly one access (we=1 write, we=0 read); cs=0 is
//          idle. A read's data is on data_out after the edge that sampled it.
// Ports:
//   clk      in   single clock, rising edge
//   rst_n    in   asynchronous active-low reset (clears data_out only)
//   address  in   [ADDR_WIDTH-1:0] word address for read and write
//   data_in  in   [DATA_WIDTH-1:0] write data
//   cs       in   chip select, active high
//   we       in   1 = write, 0 = read
//   data_out out  [DATA_WIDTH-1:0] registered read data
module ram_sp_sr_rw
    import ram_sp_sr_rw_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  cs,
    input  logic                  we,
    output logic [DATA_WIDTH-1:0] data_out
);

    // Index width actually needed to address DEPTH words.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_data_out;

    logic                  w_in_range;
    logic [IDX_W-1:0]      w_index;
    logic                  w_wr;
    logic                  w_rd;

    // Compare in 32 bits so DEPTH == 2**ADDR_WIDTH does not overflow.
    assign w_in_range = ({{(32-ADDR_WIDTH){1'b0}}, address} < 32'(DEPTH));
    // Truncation is safe: the index is only used when w_in_range is true.
    assign w_index    = IDX_W'(address);
    assign w_wr       = cs && we;
    assign w_rd       = cs && !we;

    // Storage has no reset branch so it can map onto block RAM. Writes are
    // held off while reset is asserted; earlier contents survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr && w_in_range) begin
            r_mem[w_index] <= data_in;
        end
    end

    // Output register: loads only on a read, so writes and idle cycles hold
    // the last read value. Out-of-range reads load zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out <= '0;
        end else if (w_rd) begin
            r_data_out <= w_in_range ? r_mem[w_index] : '0;
        end
    end

    assign data_out = r_data_out;

endmodule : ram_sp_sr_rw

// File: tb/tb_ram_sp_sr_rw.sv
module tb_ram_sp_sr_rw;

  localparam int DW = 8;
  localparam int AW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main DUT (DEPTH 256)
  logic [AW-1:0] address = '0;
  logic [DW-1:0] data_in = '0;
  logic          cs = 1'b0;
  logic          we = 1'b0;
  logic [DW-1:0] data_out;

  // second DUT (DEPTH 200) for out-of-range behaviour
  logic [AW-1:0] address2 = '0;
  logic [DW-1:0] data_in2 = '0;
  logic          cs2 = 1'b0;
  logic          we2 = 1'b0;
  logic [DW-1:0] data_out2;

  ram_sp_sr_rw #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .data_in(data_in),
    .cs(cs), .we(we), .data_out(data_out)
  );

  ram_sp_sr_rw #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(200)) dut2 (
    .clk(clk), .rst_n(rst_n), .address(address2), .data_in(data_in2),
    .cs(cs2), .we(we2), .data_out(data_out2)
  );

  // ---------------- model / scoreboard ----------------
  logic [DW-1:0] exp_mem [0:255];
  logic [DW-1:0] exp_out = '0;
  logic [DW-1:0] exp_q[$];
  bit            check_en = 1'b0;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: data_out against the model on every cycle.
  always @(negedge clk) begin
    if (check_en) begin
      checks++;
      if (data_out !== exp_out) begin
        errors++;
        $display("FAIL model_cmp: got %h expected %h at %0t", data_out, exp_out, $time);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One access on the main DUT; model updated at the sampling edge.
  task automatic access(input logic c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    cs = c; we = w; address = a; data_in = d;
    @(posedge clk);
    if (rst_n && c) begin
      if (w) exp_mem[a] = d;
      else   exp_out = exp_mem[a];
    end
    #1;
    cs = 1'b0;
  endtask

  task automatic access2(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    cs2 = 1'b1; we2 = w; address2 = a; data_in2 = d;
    @(posedge clk);
    #1;
    cs2 = 1'b0;
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    return DW'((i * 11 + 4) & 8'hFF);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("reset_out", data_out, 8'h00);
    rst_n = 1'b1;
    check_en = 1'b1;

    // Full write then back-to-back readback
    for (int i = 0; i < 256; i++) access(1'b1, 1'b1, AW'(i), pat(i));
    for (int i = 0; i < 256; i++) begin
      access(1'b1, 1'b0, AW'(i), 8'h00);
      if (i == 0)   check("read_addr0", data_out, 8'h04);
      if (i == 255) check("read_addr255", data_out, 8'hF9);
    end

    // Asynchronous reset clears data_out mid-cycle
    access(1'b1, 1'b1, 8'h20, 8'h5A);
    access(1'b1, 1'b0, 8'h20, 8'h00);
    check("pre_reset_5a", data_out, 8'h5A);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_out = '0;
    #1;
    check("async_reset", data_out, 8'h00);
    // Write during reset must be suppressed (addr 9 keeps 9*11+4 = 8'h67)
    access(1'b1, 1'b1, 8'h09, 8'h99);
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b1, 1'b0, 8'h09, 8'h00);
    check("reset_write_drop", data_out, 8'h67);
    access(1'b1, 1'b0, 8'h00, 8'h00);
    check("retain_addr0", data_out, 8'h04);
    access(1'b1, 1'b0, 8'hFF, 8'h00);
    check("retain_addr255", data_out, 8'hF9);

    // Read latency and hold while idle
    access(1'b1, 1'b1, 8'h10, 8'hA5);
    access(1'b1, 1'b0, 8'h10, 8'h00);
    check("latency_a5", data_out, 8'hA5);
    for (int k = 0; k < 3; k++) begin
      access(1'b0, 1'b0, AW'(8'h40 + k), 8'h00);
      check("idle_hold", data_out, 8'hA5);
    end

    // Write does not disturb data_out
    access(1'b1, 1'b1, 8'h03, 8'h33);
    access(1'b1, 1'b0, 8'h03, 8'h00);
    check("read_33", data_out, 8'h33);
    access(1'b1, 1'b1, 8'h03, 8'hCC);
    check("write_no_wt", data_out, 8'h33);
    access(1'b1, 1'b0, 8'h03, 8'h00);
    check("read_cc", data_out, 8'hCC);

    // cs gating blocks writes
    access(1'b1, 1'b1, 8'h07, 8'h07);
    access(1'b0, 1'b1, 8'h07, 8'hFF);
    access(1'b1, 1'b0, 8'h07, 8'h00);
    check("cs_gate", data_out, 8'h07);

    // Out-of-range on the DEPTH=200 instance
    access2(1'b1, 8'd199, 8'h3C);
    access2(1'b1, 8'd210, 8'h77);
    access2(1'b0, 8'd199, 8'h00);
    check("d200_read199", data_out2, 8'h3C);
    access2(1'b0, 8'd210, 8'h00);
    check("d200_oor_read", data_out2, 8'h00);
    access2(1'b0, 8'd199, 8'h00);
    check("d200_reread199", data_out2, 8'h3C);

    repeat (2) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ram_sp_sr_rw
